// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and width helper for the parametrised FIFO family.
package fifo_pkg;

    localparam int FIFO_DATA_W_DEF = 8;
    localparam int FIFO_DEPTH_DEF  = 64;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// fifo_mem_dp: DEPTH x DATA_W storage, synchronous write port, asynchronous read port.
module fifo_mem_dp
    import fifo_pkg::*;
#(
    parameter  int DATA_W = FIFO_DATA_W_DEF,
    parameter  int DEPTH  = FIFO_DEPTH_DEF,
    localparam int AW     = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with count-decoded flags, optional FWFT read
// mode and registered overflow/underflow pulses.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter  int DATA_W    = FIFO_DATA_W_DEF,
    parameter  int DEPTH     = FIFO_DEPTH_DEF,
    parameter  int AF_THRESH = DEPTH - 4,
    parameter  int AE_THRESH = 4,
    parameter  bit FWFT      = 1'b0,
    localparam int AW        = clog2(DEPTH),
    localparam int CW        = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] buf_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] buf_out,
    output logic              buf_empty,
    output logic              buf_full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [CW-1:0]     fifo_counter,
    output logic              overflow,
    output logic              underflow
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AF_THRESH < 1 || AF_THRESH > DEPTH ||
        AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_params
        $error("sync_fifo_param: illegal DEPTH/threshold parameters");
    end

    logic [AW-1:0]     wrptr_q, wrptr_d, rdptr_q, rdptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d, mem_rd;
    logic              ovf_q, unf_q, wr_acc, rd_acc;

    assign buf_empty    = count_q == '0;
    assign buf_full     = count_q == CW'(DEPTH);
    assign almost_empty = count_q <= CW'(AE_THRESH);
    assign almost_full  = count_q >= CW'(AF_THRESH);
    assign fifo_counter = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
    assign buf_out      = FWFT ? mem_rd : dout_q;

    // acceptance uses the pre-edge flags, so a full FIFO refuses writes even while popping
    assign wr_acc = wr_en && !buf_full && !rst;
    assign rd_acc = rd_en && !buf_empty;

    always_comb begin
        wrptr_d = wr_acc ? wrptr_q + AW'(1) : wrptr_q;
        rdptr_d = rd_acc ? rdptr_q + AW'(1) : rdptr_q;
        count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
        dout_d  = rd_acc ? mem_rd : dout_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrptr_q <= '0;
            rdptr_q <= '0;
            count_q <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wrptr_q <= wrptr_d;
            rdptr_q <= rdptr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
            ovf_q   <= wr_en && buf_full;
            unf_q   <= rd_en && buf_empty;
        end
    end

    fifo_mem_dp #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wrptr_q),
        .wdata_i (buf_in),
        .raddr_i (rdptr_q),
        .rdata_o (mem_rd)
    );

endmodule
